// File: rtl/game_level_select.sv
// game_level_select: debounced, registered level selector for the maze game.
// Raw switches must hold one value for STABLE_CYCLES samples before a level is committed.
// A committed level drives a one-hot play enable, a level index, and the +5/-5 score
// tile coordinates taken from the parameter tables.
// Optional feature macro: GAME_LEVEL_LOCK_EN. When it is defined, a level change is held
// off while gameActive is high. Dropping to no selection is never held off.
module game_level_select #(
    parameter int NUM_LEVELS    = 3,
    parameter int COORD_W       = 5,
    parameter int STABLE_CYCLES = 4,
    parameter logic [NUM_LEVELS*COORD_W-1:0] PLUS_X_TABLE  = {5'd1, 5'd21, 5'd17},
    parameter logic [NUM_LEVELS*COORD_W-1:0] PLUS_Y_TABLE  = {5'd21, 5'd4, 5'd9},
    parameter logic [NUM_LEVELS*COORD_W-1:0] MINUS_X_TABLE = {5'd3, 5'd10, 5'd10},
    parameter logic [NUM_LEVELS*COORD_W-1:0] MINUS_Y_TABLE = {5'd5, 5'd6, 5'd9},
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NUM_LEVELS-1:0] sel,
    input  logic                  gameActive,
    output logic [NUM_LEVELS-1:0] levelOneHot,
    output logic [LVL_W-1:0]      levelIdx,
    output logic                  levelValid,
    output logic                  externalReset,
    output logic                  levelChanged,
    output logic                  selError,
    output logic [COORD_W-1:0]    scorePlusFiveX,
    output logic [COORD_W-1:0]    scorePlusFiveY,
    output logic [COORD_W-1:0]    scoreMinusFiveX,
    output logic [COORD_W-1:0]    scoreMinusFiveY
);

    // STABLE_CYCLES >= 2, so CNT_W is at least 1 and always holds STABLE_CYCLES-1.
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                state;
    logic [NUM_LEVELS-1:0] sel_q;
    logic [CNT_W-1:0]      cnt;
    logic                  qualified;
    logic                  sel_none;
    logic                  sel_one;
    logic                  sel_multi;
    logic                  lock_hold;
    logic                  do_commit;
    logic                  do_idle;
    logic [LVL_W-1:0]      new_idx;

    function automatic int unsigned bit_count(input logic [NUM_LEVELS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [LVL_W-1:0] idx_of(input logic [NUM_LEVELS-1:0] v);
        logic [LVL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (v[i]) idx = LVL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [COORD_W-1:0] coord(input logic [NUM_LEVELS*COORD_W-1:0] tbl,
                                                 input logic [LVL_W-1:0] idx);
        return tbl[int'(idx)*COORD_W +: COORD_W];
    endfunction

`ifdef GAME_LEVEL_LOCK_EN
    // A running game freezes the level until gameActive drops.
    assign lock_hold = gameActive;
`else
    // gameActive has no effect in this build.
    logic unused_game_active;
    assign unused_game_active = gameActive;
    assign lock_hold          = 1'b0;
`endif

    // Classify the filtered selection and decide whether this edge commits.
    always_comb begin
        qualified = (sel == sel_q) && (cnt == CNT_MAX);
        sel_none  = (sel_q == '0);
        sel_one   = (bit_count(sel_q) == 1);
        sel_multi = (bit_count(sel_q) > 1);
        new_idx   = idx_of(sel_q);
        do_idle   = qualified && sel_none && (state == PLAY);
        do_commit = qualified && sel_one &&
                    ((state == IDLE) || ((sel_q != levelOneHot) && !lock_hold));
    end

    // Stability filter: count consecutive identical samples, saturating at STABLE_CYCLES-1.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            sel_q <= sel;
            if (sel != sel_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Level FSM with registered outputs; all committed outputs update on the same edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state           <= IDLE;
            levelOneHot     <= '0;
            levelIdx        <= '0;
            levelValid      <= 1'b0;
            externalReset   <= 1'b1;
            levelChanged    <= 1'b0;
            selError        <= 1'b0;
            scorePlusFiveX  <= '0;
            scorePlusFiveY  <= '0;
            scoreMinusFiveX <= '0;
            scoreMinusFiveY <= '0;
        end else begin
            selError     <= sel_multi;
            levelChanged <= 1'b0;
            if (do_idle) begin
                state           <= IDLE;
                levelOneHot     <= '0;
                levelIdx        <= '0;
                levelValid      <= 1'b0;
                externalReset   <= 1'b1;
                levelChanged    <= 1'b1;
                scorePlusFiveX  <= '0;
                scorePlusFiveY  <= '0;
                scoreMinusFiveX <= '0;
                scoreMinusFiveY <= '0;
            end else if (do_commit) begin
                state           <= PLAY;
                levelOneHot     <= sel_q;
                levelIdx        <= new_idx;
                levelValid      <= 1'b1;
                externalReset   <= 1'b0;
                levelChanged    <= 1'b1;
                scorePlusFiveX  <= coord(PLUS_X_TABLE, new_idx);
                scorePlusFiveY  <= coord(PLUS_Y_TABLE, new_idx);
                scoreMinusFiveX <= coord(MINUS_X_TABLE, new_idx);
                scoreMinusFiveY <= coord(MINUS_Y_TABLE, new_idx);
            end
        end
    end

endmodule

// File: tb/tb_game_level_select.sv
// Directed bench for game_level_select with default parameters.
// Expected output vectors are written out by hand per level.
module tb_game_level_select;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] sel;
    logic       gameActive;
    logic [2:0] levelOneHot;
    logic [1:0] levelIdx;
    logic       levelValid;
    logic       externalReset;
    logic       levelChanged;
    logic       selError;
    logic [4:0] scorePlusFiveX;
    logic [4:0] scorePlusFiveY;
    logic [4:0] scoreMinusFiveX;
    logic [4:0] scoreMinusFiveY;

    int vectors     = 0;
    int miscompares = 0;

    typedef logic [28:0] obs_t;

    game_level_select dut (
        .clock(clock),
        .resetn(resetn),
        .sel(sel),
        .gameActive(gameActive),
        .levelOneHot(levelOneHot),
        .levelIdx(levelIdx),
        .levelValid(levelValid),
        .externalReset(externalReset),
        .levelChanged(levelChanged),
        .selError(selError),
        .scorePlusFiveX(scorePlusFiveX),
        .scorePlusFiveY(scorePlusFiveY),
        .scoreMinusFiveX(scoreMinusFiveX),
        .scoreMinusFiveY(scoreMinusFiveY)
    );

    always #5 clock = ~clock;

    // Observed outputs packed in a fixed order.
    function automatic obs_t snap();
        return {levelOneHot, levelIdx, levelValid, externalReset, levelChanged, selError,
                scorePlusFiveX, scorePlusFiveY, scoreMinusFiveX, scoreMinusFiveY};
    endfunction

    // Hand-written expected outputs: lvl -1 = no level committed.
    function automatic obs_t expect_lvl(input int lvl, input logic chg, input logic err);
        case (lvl)
            0:       return {3'b001, 2'd0, 1'b1, 1'b0, chg, err, 5'd17, 5'd9, 5'd10, 5'd9};
            1:       return {3'b010, 2'd1, 1'b1, 1'b0, chg, err, 5'd21, 5'd4, 5'd10, 5'd6};
            2:       return {3'b100, 2'd2, 1'b1, 1'b0, chg, err, 5'd1, 5'd21, 5'd3, 5'd5};
            default: return {3'b000, 2'd0, 1'b0, 1'b1, chg, err, 20'd0};
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        resetn     = 1'b0;
        sel        = 3'b000;
        gameActive = 1'b0;
        tick();
        tick();
        e = expect_lvl(-1, 1'b0, 1'b0);
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", snap(), e);
        end
        resetn = 1'b1;
    endtask

    task automatic test_select_easy();
        obs_t e;
        sel = 3'b001;
        for (int i = 1; i <= 6; i++) begin
            tick();
            e = (i < 5) ? expect_lvl(-1, 1'b0, 1'b0) : expect_lvl(0, i == 5, 1'b0);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL select_easy edge %0d: got %h expected %h", i, snap(), e);
            end
        end
    endtask

    task automatic test_glitch();
        obs_t e;
        e = expect_lvl(0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            sel = (i <= 3) ? 3'b100 : 3'b001;
            tick();
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL glitch edge %0d: got %h expected %h", i, snap(), e);
            end
        end
    endtask

    task automatic test_multi_hot();
        obs_t e;
        sel = 3'b110;
        for (int i = 1; i <= 10; i++) begin
            tick();
            e = expect_lvl(0, 1'b0, i >= 2);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL multi_hot edge %0d: got %h expected %h", i, snap(), e);
            end
        end
        sel = 3'b010;
        for (int i = 1; i <= 6; i++) begin
            tick();
            e = expect_lvl((i < 5) ? 0 : 1, i == 5, i == 1);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL multi_then_medium edge %0d: got %h expected %h", i, snap(), e);
            end
        end
    endtask

    task automatic test_drop_to_none();
        obs_t e;
        sel = 3'b100;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = expect_lvl((i < 5) ? 1 : 2, i == 5, 1'b0);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL select_hard edge %0d: got %h expected %h", i, snap(), e);
            end
        end
        sel = 3'b000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            e = expect_lvl((i < 5) ? 2 : -1, i == 5, 1'b0);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL drop_to_none edge %0d: got %h expected %h", i, snap(), e);
            end
        end
    endtask

    task automatic test_lock();
        obs_t e;
        sel = 3'b001;
        repeat (5) tick();
        e = expect_lvl(0, 1'b1, 1'b0);
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL lock_setup_easy: got %h expected %h", snap(), e);
        end
        gameActive = 1'b1;
        sel        = 3'b100;
        for (int i = 1; i <= 8; i++) begin
            tick();
`ifdef GAME_LEVEL_LOCK_EN
            e = expect_lvl(0, 1'b0, 1'b0);
`else
            e = expect_lvl((i < 5) ? 0 : 2, i == 5, 1'b0);
`endif
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL lock_active edge %0d: got %h expected %h", i, snap(), e);
            end
        end
        gameActive = 1'b0;
        tick();
`ifdef GAME_LEVEL_LOCK_EN
        e = expect_lvl(2, 1'b1, 1'b0);
`else
        e = expect_lvl(2, 1'b0, 1'b0);
`endif
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL lock_release: got %h expected %h", snap(), e);
        end
        gameActive = 1'b1;
        sel        = 3'b000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = expect_lvl((i < 5) ? 2 : -1, i == 5, 1'b0);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL lock_drop_none edge %0d: got %h expected %h", i, snap(), e);
            end
        end
        gameActive = 1'b0;
    endtask

    task automatic test_reset_midplay();
        obs_t e;
        sel = 3'b010;
        repeat (5) tick();
        e = expect_lvl(1, 1'b1, 1'b0);
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL midplay_setup: got %h expected %h", snap(), e);
        end
        resetn = 1'b0;
        tick();
        e = expect_lvl(-1, 1'b0, 1'b0);
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL midplay_reset: got %h expected %h", snap(), e);
        end
        resetn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = expect_lvl((i < 5) ? -1 : 1, i == 5, 1'b0);
            vectors++;
            if (snap() !== e) begin
                miscompares++;
                $display("FAIL after_reset edge %0d: got %h expected %h", i, snap(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select_easy();
        test_glitch();
        test_multi_hot();
        test_drop_to_none();
        test_lock();
        test_reset_midplay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
